toast_dmem_subsys: RTL
======================

// Module: toast_dmem_subsys
// PURPOSE
//  Data-memory subsystem directly downstream of the core's MEM stage; it consumes DMEM_addr/_wr_data/_wr_en/_rst.
//  - Word-wide synchronous data RAM.
//  - Memory-mapped GPIO output register.
//  - 8N1 UART transmitter with status register.
//  - Optional 64-bit machine timer with interrupt.
//  Returns registered DMEM_rd_data with 1-cycle latency, matching the MEM/WB pipeline timing.
// PARAMETERS
//  RAM_DEPTH     1024  number of 32-bit RAM words; power of 2
//  CLKS_PER_BIT  868   UART bit period in Clk cycles (100 MHz / 115200); legal range >= 2
//  GPIO_W        8     width of the GPIO output register
// PORTS
//  Clk           in   1       clock; all logic on rising edge
//  Reset         in   1       synchronous, active-high reset
//  DMEM_addr     in   32      byte address; bits [1:0] ignored, word accesses only
//  DMEM_wr_data  in   32      store data
//  DMEM_wr_en    in   1       store strobe for the current cycle
//  DMEM_rst      in   1       clears the read-data register (bubble/flush)
//  DMEM_rd_data  out  32      registered load data
//  GPIO_out      out  GPIO_W  GPIO output register
//  UART_tx       out  1       serial line; idles high
//  Timer_irq     out  1       mtime >= mtimecmp (TOAST_DMEM_TIMER_EN only; otherwise tied 0)
// BEHAVIOUR
//  Reset values:
//   - DMEM_rd_data=0, GPIO_out=0, UART_tx=1, FSM=IDLE, busy=0, overflow=0.
//   - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, Timer_irq=0.
//   - RAM contents are not reset.
//  Address map:
//   - RAM: 0x0000_0000 + 4*i, i < RAM_DEPTH; RAM index = addr[log2(RAM_DEPTH)+1:2].
//   - Beyond RAM_DEPTH in the 0x0xxx_xxxx region: unmapped.
//   - MMIO base 0x8000_0000:
//       +00 GPIO (RW, low GPIO_W bits; upper read bits 0)
//       +04 UART_DATA (W, byte [7:0]; reads 0)
//       +08 UART_STATUS (R: b0=busy, b1=overflow; W: write 1 to b1 clears overflow)
//       +10/+14 MTIME lo/hi; +18/+1C MTIMECMP lo/hi
//   - Any other address: reads 0, writes ignored.
//  Reads:
//   - DMEM_rd_data updates at the edge after the address is presented.
//   - Read-during-write to the same location returns the OLD value (RAM and MMIO).
//   - DMEM_rst=1 forces DMEM_rd_data to 0 at the next edge; it overrides any read and does not block a store.
//  UART:
//   - A write to UART_DATA while idle loads the shift register.
//   - busy rises at the next edge. Frame: START(0) -> DATA b0..b7 LSB first -> STOP(1).
//   - Each bit lasts exactly CLKS_PER_BIT cycles. busy falls after the STOP bit completes.
//   - FSM: IDLE -> START -> DATA (3-bit index, 0..7) -> STOP -> IDLE.
//   - Baud counter runs 0..CLKS_PER_BIT-1, then wraps and advances the state.
//   - A write while busy is dropped, sets sticky overflow, and leaves the current frame undisturbed.
//   - Reset mid-frame: UART_tx=1 and FSM=IDLE at the next edge; the partial frame is abandoned.
//  Timer:
//   - mtime increments by 1 every cycle and wraps at 2^64 to 0.
//   - A write to a MTIME half replaces that half this edge, in place of the increment.
//   - Timer_irq is registered: (mtime >= mtimecmp), unsigned 64-bit compare, 1-cycle lag.
//   - A write to MTIMECMP lower than mtime raises irq at the edge after the write.
// CONFIGURATION
//  TOAST_DMEM_TIMER_EN defined: MTIME/MTIMECMP registers and Timer_irq are implemented as above.
//  Undefined: no timer logic; offsets +10..+1C read 0 and ignore writes; Timer_irq tied to 0.
// STRUCTURE
//  Package toast_dmem_pkg:
//   - MMIO_BASE and the register offset localparams.
//   - uart_state_t enum {IDLE, START, DATA, STOP}.
//   - Function decoding an address to a region enum {RAM, MMIO_REG, UNMAPPED}.
//  Sub-module toast_uart_tx (CLKS_PER_BIT): ports Clk, Reset, Load, Data[7:0], Busy, Tx.
//  Top: address decode, RAM array, GPIO/status/timer registers, read mux, output register.
// TESTING
//  1. Write 0xDEADBEEF to 0x40, then read 0x40 -> rd_data=0xDEADBEEF exactly 1 cycle after the address.
//  2. Same-cycle write 0x1 and read of 0x40 (old value 0x5) -> 0x5; next-cycle read -> 0x1.
//     Read 0x40 with DMEM_rst=1 -> rd_data=0.
//  3. Write 0xA5 to 0x8000_0004, CLKS_PER_BIT=4 -> UART_tx = 0,1,0,1,0,0,1,0,1,1, 4 cycles each.
//     busy=1 for exactly 40 cycles.
//  4. Write 0x11 during a busy frame -> frame unchanged, STATUS reads 0x3.
//     Write 0x2 to STATUS -> STATUS reads 0x1. Assert Reset mid-frame -> UART_tx=1 next cycle.
//  5. Write 0xFFFF_FFFF to GPIO with GPIO_W=8 -> GPIO_out=0xFF, readback 0x0000_00FF.
//     Read 0x8000_0100 -> 0.
//  6. (TIMER_EN) Write MTIME_LO=0xFFFF_FFFE, HI=0 -> mtime HI reads 1 after 2 cycles.
//     Set MTIMECMP={0,10} after Reset -> irq rises at cycle 11.

Source files
------------

// File: rtl/toast_dmem_pkg.sv
// Shared definitions for the TOAST data-memory subsystem: MMIO register map,
// UART transmitter states, request bundle and address-region decode.
package toast_dmem_pkg;

  localparam logic [31:0] MMIO_BASE       = 32'h8000_0000;
  localparam logic [7:0]  OFF_GPIO        = 8'h00;
  localparam logic [7:0]  OFF_UART_DATA   = 8'h04;
  localparam logic [7:0]  OFF_UART_STATUS = 8'h08;
  localparam logic [7:0]  OFF_MTIME_LO    = 8'h10;
  localparam logic [7:0]  OFF_MTIME_HI    = 8'h14;
  localparam logic [7:0]  OFF_MTIMECMP_LO = 8'h18;
  localparam logic [7:0]  OFF_MTIMECMP_HI = 8'h1C;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  typedef enum logic [1:0] {RAM, MMIO_REG, UNMAPPED} region_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        wr_en;
  } dmem_req_t;

  // Takes the word address (byte address >> 2); the MMIO window is one 256-byte page.
  function automatic region_t decode_region(input logic [29:0] waddr, input int ram_depth);
    if ({2'b00, waddr} < $unsigned(ram_depth)) return RAM;
    if (waddr[29:6] == MMIO_BASE[31:8]) return MMIO_REG;
    return UNMAPPED;
  endfunction

endpackage

// File: rtl/toast_uart_tx.sv
// 8N1 UART transmitter: START(0), eight data bits LSB first, STOP(1),
// each bit held for CLKS_PER_BIT clocks. Load is ignored while Busy.
module toast_uart_tx
  import toast_dmem_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Load,
  input  logic [7:0] Data,
  output logic       Busy,
  output logic       Tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          wrap;

  assign wrap = (cnt == CW'(CLKS_PER_BIT - 1));
  assign Busy = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      Tx    <= 1'b1;
    end else begin
      cnt <= (state == IDLE || wrap) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (Load) begin
          shreg <= Data;
          state <= START;
          Tx    <= 1'b0;
        end
        START: if (wrap) begin
          state <= DATA;
          idx   <= '0;
          Tx    <= shreg[0];
        end
        DATA: if (wrap) begin
          // shreg[0] is the bit now on the line, so shreg[1] is the next one
          shreg <= shreg >> 1;
          idx   <= idx + 1'b1;
          if (idx == 3'd7) begin
            state <= STOP;
            Tx    <= 1'b1;
          end else begin
            Tx <= shreg[1];
          end
        end
        STOP: if (wrap) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/toast_dmem_subsys.sv
// Data-memory subsystem behind the MEM stage: word RAM, GPIO, UART TX, optional timer.
// Define TOAST_DMEM_TIMER_EN to build the 64-bit mtime/mtimecmp timer and Timer_irq.
module toast_dmem_subsys
  import toast_dmem_pkg::*;
#(
  parameter int RAM_DEPTH    = 1024,
  parameter int CLKS_PER_BIT = 868,
  parameter int GPIO_W       = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       DMEM_addr,
  input  logic [31:0]       DMEM_wr_data,
  input  logic              DMEM_wr_en,
  input  logic              DMEM_rst,
  output logic [31:0]       DMEM_rd_data,
  output logic [GPIO_W-1:0] GPIO_out,
  output logic              UART_tx,
  output logic              Timer_irq
);

  localparam int AW = $clog2(RAM_DEPTH);

  dmem_req_t         req;
  region_t           rgn;
  logic [7:0]        off;
  logic [AW-1:0]     ram_idx;
  logic              mmio_wr, uart_busy, uart_load, ovf;
  logic [31:0]       mem [RAM_DEPTH];
  logic [GPIO_W-1:0] gpio;
  logic [31:0]       mmio_rd, rd_next;
  logic              unused_addr_lsb;

  assign req             = '{addr: DMEM_addr, wr_data: DMEM_wr_data, wr_en: DMEM_wr_en};
  assign unused_addr_lsb = ^req.addr[1:0];
  assign rgn             = decode_region(req.addr[31:2], RAM_DEPTH);
  assign off             = {req.addr[7:2], 2'b00};
  assign ram_idx         = req.addr[AW+1:2];
  assign mmio_wr         = req.wr_en && (rgn == MMIO_REG);
  assign uart_load       = mmio_wr && (off == OFF_UART_DATA) && !uart_busy;
  assign GPIO_out        = gpio;

  always_ff @(posedge Clk)
    if (req.wr_en && rgn == RAM) mem[ram_idx] <= req.wr_data;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      gpio <= '0;
      ovf  <= 1'b0;
    end else if (mmio_wr) begin
      if (off == OFF_GPIO) gpio <= req.wr_data[GPIO_W-1:0];
      if (off == OFF_UART_DATA && uart_busy) ovf <= 1'b1;
      if (off == OFF_UART_STATUS && req.wr_data[1]) ovf <= 1'b0;
    end
  end

  toast_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (uart_load),
    .Data  (req.wr_data[7:0]),
    .Busy  (uart_busy),
    .Tx    (UART_tx)
  );

`ifdef TOAST_DMEM_TIMER_EN
  logic [63:0] mtime, mtimecmp;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      Timer_irq <= 1'b0;
    end else begin
      Timer_irq <= (mtime >= mtimecmp);
      // a half-word write replaces the whole update for this cycle
      if (mmio_wr && off == OFF_MTIME_LO)      mtime[31:0]  <= req.wr_data;
      else if (mmio_wr && off == OFF_MTIME_HI) mtime[63:32] <= req.wr_data;
      else                                     mtime        <= mtime + 64'd1;
      if (mmio_wr && off == OFF_MTIMECMP_LO) mtimecmp[31:0]  <= req.wr_data;
      if (mmio_wr && off == OFF_MTIMECMP_HI) mtimecmp[63:32] <= req.wr_data;
    end
  end
`else
  assign Timer_irq = 1'b0;
`endif

  // Read path samples pre-edge state, so read-during-write returns the old value.
  always_comb begin
    mmio_rd = '0;
    case (off)
      OFF_GPIO:        mmio_rd = 32'(gpio);
      OFF_UART_STATUS: mmio_rd = {30'd0, ovf, uart_busy};
`ifdef TOAST_DMEM_TIMER_EN
      OFF_MTIME_LO:    mmio_rd = mtime[31:0];
      OFF_MTIME_HI:    mmio_rd = mtime[63:32];
      OFF_MTIMECMP_LO: mmio_rd = mtimecmp[31:0];
      OFF_MTIMECMP_HI: mmio_rd = mtimecmp[63:32];
`endif
      default:         mmio_rd = '0;
    endcase
    rd_next = '0;
    if (rgn == RAM)           rd_next = mem[ram_idx];
    else if (rgn == MMIO_REG) rd_next = mmio_rd;
  end

  always_ff @(posedge Clk)
    if (Reset || DMEM_rst) DMEM_rd_data <= '0;
    else                   DMEM_rd_data <= rd_next;

endmodule
